uart_tx_arbiter: RTL and testbench

//  Shares the single basic_uart transmitter between N_REQ byte-stream requesters.

---
 rtl/uart_tx_arbiter_pkg.sv | 19 +
 rtl/uart_tx_arbiter_rr.sv | 31 +++
 rtl/uart_tx_arbiter.sv | 113 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART transmit arbiter; no logic, no latency.
// FSM encoding, default UART timing and the round-robin wrap helper.
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  localparam int CLK_FRE   = 50_000_000;
  localparam int BAUD_RATE = 115_200;
  localparam int DIVISOR   = CLK_FRE / BAUD_RATE;

  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// Rotating-priority pick: first valid index from rr_ptr upward, combinational, zero latency.
// No backpressure; one-hot result is all zeros when nothing is valid.
module uart_rr_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int PW    = 2
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [PW-1:0]    rr_ptr,
  output logic [N_REQ-1:0] pick_oh,
  output logic [PW-1:0]    pick_idx
);

  always_comb begin
    int idx;
    pick_oh  = '0;
    pick_idx = '0;
    idx      = 0;
    // Scan highest offset first so the lowest offset from rr_ptr wins.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % N_REQ;
      if (req_valid[idx]) begin
        pick_oh      = '0;
        pick_oh[idx] = 1'b1;
        pick_idx     = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin share of one UART transmitter; handshake -> tx_wr_ev next cycle.
// Backpressure: req_ready only on the granted slot while tx_ready; stall abort with UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CYC = 5000
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_data,
  input  logic [N_REQ-1:0]     req_last,
  output logic [N_REQ-1:0]     req_ready,
  input  logic                 tx_ready,
  input  logic                 tx_done_ev,
  output logic [7:0]           tx_dat,
  output logic                 tx_wr_ev,
  output logic [N_REQ-1:0]     grant,
  output logic                 busy,
  output logic                 timeout_ev
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t           state, state_nxt;
  logic [PW-1:0]    rr_ptr, g_idx, pick_idx, g_inc;
  logic [N_REQ-1:0] pick_oh;
  logic             last_q, hs, done_ok, stall, tmo_hit, release_g;

  uart_rr_arbiter #(.N_REQ(N_REQ), .PW(PW)) u_rr (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .pick_oh   (pick_oh),
    .pick_idx  (pick_idx)
  );

  assign stall     = (state == ST_SEND) && !req_valid[g_idx];
  assign hs        = (state == ST_SEND) && req_valid[g_idx] && tx_ready;
  assign req_ready = hs ? grant : '0;
  // The done pulse in the write-strobe cycle belongs to the previous byte.
  assign done_ok   = (state == ST_WAIT) && tx_done_ev && !tx_wr_ev;
  assign g_inc     = PW'(wrap_inc(int'(g_idx), N_REQ));
  assign release_g = (done_ok && last_q) || tmo_hit;
  assign busy      = (state != ST_IDLE);

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] stall_cnt;

  assign tmo_hit = stall && (stall_cnt == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (state != ST_SEND || hs) begin
      stall_cnt <= '0;
    end else if (stall) begin
      stall_cnt <= stall_cnt + CW'(1);
    end
  end
`else
  logic tmo_unused;
  assign tmo_unused = (TIMEOUT_CYC > 0);
  assign tmo_hit    = 1'b0;
`endif

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (|req_valid) state_nxt = ST_SEND;
      ST_SEND: begin
        if (tmo_hit)  state_nxt = ST_IDLE;
        else if (hs)  state_nxt = ST_WAIT;
      end
      ST_WAIT: if (done_ok) state_nxt = last_q ? ST_IDLE : ST_SEND;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      grant      <= '0;
      g_idx      <= '0;
      rr_ptr     <= '0;
      last_q     <= 1'b0;
      tx_dat     <= 8'h00;
      tx_wr_ev   <= 1'b0;
      timeout_ev <= 1'b0;
    end else begin
      tx_wr_ev   <= hs;
      timeout_ev <= tmo_hit;
      if (state == ST_IDLE && |req_valid) begin
        grant <= pick_oh;
        g_idx <= pick_idx;
      end
      if (hs) begin
        tx_dat <= req_data[8*int'(g_idx) +: 8];
        last_q <= req_last[g_idx];
      end
      if (release_g) begin
        grant  <= '0;
        rr_ptr <= g_inc;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: behavioural UART transmitter, per-requester byte queues,
// scoreboard of expected {byte, grant} popped on every tx_wr_ev.
module tb_uart_tx_arbiter;

  localparam int BYTE_CYC = 20;

  typedef struct {
    logic [7:0] dat;
    logic [3:0] gnt;
  } exp_t;

  typedef struct {
    logic [3:0] mask;
    logic [7:0] base;
    int         n;
    logic [7:0] order;
  } vec_t;

  logic        sys_clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_last = '0;
  logic [3:0]  req_ready;
  logic        tx_ready = 1'b1;
  logic        tx_done_ev = 1'b0;
  logic [7:0]  tx_dat;
  logic        tx_wr_ev;
  logic [3:0]  grant;
  logic        busy;
  logic        timeout_ev;

  logic [8:0]  rq [4][$];
  exp_t        exp_q [$];
  logic [3:0]  hold = '0;
  logic [3:0]  hs_mask;
  int          tcnt = 0;
  int          total = 0;
  int          bad = 0;
  int          tmo_cnt = 0;
  int          cyc = 0;
  vec_t        vt [8];

  uart_tx_arbiter #(.N_REQ(4), .TIMEOUT_CYC(100)) dut (
    .sys_clk    (sys_clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .tx_ready   (tx_ready),
    .tx_done_ev (tx_done_ev),
    .tx_dat     (tx_dat),
    .tx_wr_ev   (tx_wr_ev),
    .grant      (grant),
    .busy       (busy),
    .timeout_ev (timeout_ev)
  );

  always #10 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Transmitter model: busy for BYTE_CYC cycles per byte, then a one-cycle done pulse.
  always @(posedge sys_clk) begin
    cyc        <= cyc + 1;
    tx_done_ev <= 1'b0;
    if (tcnt > 0) begin
      tcnt <= tcnt - 1;
      if (tcnt == 1) begin
        tx_done_ev <= 1'b1;
        tx_ready   <= 1'b1;
      end
    end else if (tx_wr_ev) begin
      tx_ready <= 1'b0;
      tcnt     <= BYTE_CYC;
    end
  end

  // Requester driver: pop on handshake, present queue heads unless held.
  always begin
    @(negedge sys_clk);
    hs_mask = req_ready & req_valid;
    @(posedge sys_clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      logic [8:0] h;
      if (hs_mask[i] && rq[i].size() > 0) void'(rq[i].pop_front());
      h = (rq[i].size() > 0) ? rq[i][0] : 9'h000;
      req_valid[i]        = (rq[i].size() > 0) && !hold[i];
      req_data[8*i +: 8]  = h[7:0];
      req_last[i]         = h[8];
    end
  end

  // Scoreboard and protocol monitors.
  always @(negedge sys_clk) begin
    if (rst) begin
      if (tx_wr_ev) begin
        if (exp_q.size() == 0) begin
          check("unexpected_wr", {24'h0, tx_dat}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("tx_dat", {24'h0, tx_dat}, {24'h0, e.dat});
          check("grant_at_wr", {28'h0, grant}, {28'h0, e.gnt});
        end
      end
      if (req_ready != 4'b0) check("ready_outside_grant", {28'h0, req_ready & ~grant}, 32'h0);
      if (timeout_ev) tmo_cnt++;
    end
  end

  task automatic wait_drain(input int budget, input string name);
    int c = 0;
    while ((exp_q.size() != 0 || busy) && c < budget) begin
      @(negedge sys_clk);
      c++;
    end
    total++;
    if (c >= budget) begin
      bad++;
      $display("FAIL %s drain pending=%0d busy=%0b required pending=0 busy=0", name, exp_q.size(), busy);
      exp_q.delete();
    end
  endtask

  task automatic wait_wr(input int budget, input string name);
    int c = 0;
    while (!tx_wr_ev && c < budget) begin
      @(negedge sys_clk);
      c++;
    end
    total++;
    if (c >= budget) begin
      bad++;
      $display("FAIL %s no tx_wr_ev within %0d cycles", name, budget);
    end
  endtask

  initial begin
    int t0;
    int c;
    vt[0] = '{mask: 4'b1111, base: 8'h10, n: 4, order: 8'hE4};
    vt[1] = '{mask: 4'b1111, base: 8'h10, n: 4, order: 8'hE4};
    vt[2] = '{mask: 4'b1010, base: 8'h40, n: 2, order: 8'h0D};
    vt[3] = '{mask: 4'b0110, base: 8'h60, n: 2, order: 8'h09};
    vt[4] = '{mask: 4'b1001, base: 8'h80, n: 2, order: 8'h03};
    vt[5] = '{mask: 4'b0101, base: 8'hC0, n: 2, order: 8'h02};
    vt[6] = '{mask: 4'b0001, base: 8'hE0, n: 1, order: 8'h00};
    vt[7] = '{mask: 4'b1000, base: 8'hF0, n: 1, order: 8'h03};

    rst = 1'b0;
    #45;
    check("rst_grant", {28'h0, grant}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_tx_wr_ev", {31'h0, tx_wr_ev}, 32'h0);
    check("rst_tx_dat", {24'h0, tx_dat}, 32'h0);
    check("rst_timeout_ev", {31'h0, timeout_ev}, 32'h0);
    check("rst_req_ready", {28'h0, req_ready}, 32'h0);
    #55;
    rst = 1'b1;
    repeat (2) @(negedge sys_clk);

    // Simultaneous single-byte packets; order field lists expected requester sequence.
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 4; i++)
        if (vt[r].mask[i]) rq[i].push_back({1'b1, vt[r].base + 8'(i)});
      for (int k = 0; k < vt[r].n; k++) begin
        exp_t e;
        logic [1:0] id;
        id    = vt[r].order[2*k +: 2];
        e.dat = vt[r].base + 8'(id);
        e.gnt = 4'b0001 << id;
        exp_q.push_back(e);
      end
      wait_drain(2000, $sformatf("vec%0d", r));
    end

    // Req2 mid-packet holds off req1 until its last byte completes.
    rq[2].push_back({1'b0, 8'hA0});
    rq[2].push_back({1'b0, 8'hA1});
    rq[2].push_back({1'b1, 8'hA2});
    exp_q.push_back('{dat: 8'hA0, gnt: 4'b0100});
    exp_q.push_back('{dat: 8'hA1, gnt: 4'b0100});
    exp_q.push_back('{dat: 8'hA2, gnt: 4'b0100});
    exp_q.push_back('{dat: 8'hB0, gnt: 4'b0010});
    c = 0;
    while (grant != 4'b0100 && c < 100) begin
      @(negedge sys_clk);
      c++;
    end
    check("t3_grant_req2", {28'h0, grant}, 32'h4);
    rq[1].push_back({1'b1, 8'hB0});
    wait_drain(2000, "t3");

    // Two-byte packet from req0, grant released afterwards.
    rq[0].push_back({1'b0, 8'h55});
    rq[0].push_back({1'b1, 8'hA3});
    exp_q.push_back('{dat: 8'h55, gnt: 4'b0001});
    exp_q.push_back('{dat: 8'hA3, gnt: 4'b0001});
    wait_drain(2000, "t1");
    check("t1_grant_after", {28'h0, grant}, 32'h0);

    // Reset while waiting on the first byte of a packet.
    rq[0].push_back({1'b0, 8'h21});
    rq[0].push_back({1'b1, 8'h22});
    exp_q.push_back('{dat: 8'h21, gnt: 4'b0001});
    wait_wr(200, "t4_first_wr");
    repeat (3) @(negedge sys_clk);
    rst = 1'b0;
    #1;
    check("t4_rst_grant", {28'h0, grant}, 32'h0);
    check("t4_rst_busy", {31'h0, busy}, 32'h0);
    check("t4_rst_tx_wr_ev", {31'h0, tx_wr_ev}, 32'h0);
    rq[0].delete();
    check("t4_no_pending_exp", exp_q.size(), 32'h0);
    exp_q.delete();
    repeat (2) @(negedge sys_clk);
    rst = 1'b1;
    rq[0].push_back({1'b0, 8'h31});
    rq[0].push_back({1'b1, 8'h32});
    exp_q.push_back('{dat: 8'h31, gnt: 4'b0001});
    exp_q.push_back('{dat: 8'h32, gnt: 4'b0001});
    wait_drain(2000, "t4_after");

    // Req1 stalls after its first byte; req2 waits behind it.
    rq[1].push_back({1'b0, 8'hD0});
    rq[1].push_back({1'b0, 8'hD1});
    rq[1].push_back({1'b1, 8'hD2});
    rq[2].push_back({1'b1, 8'hE0});
    exp_q.push_back('{dat: 8'hD0, gnt: 4'b0010});
    wait_wr(200, "t5_first_wr");
    t0 = cyc;
    hold[1] = 1'b1;
`ifdef UART_TX_ARB_TIMEOUT_EN
    exp_q.push_back('{dat: 8'hE0, gnt: 4'b0100});
    c = 0;
    while (!timeout_ev && c < 400) begin
      @(negedge sys_clk);
      c++;
    end
    check("t5_timeout_seen", {31'h0, timeout_ev}, 32'h1);
    check("t5_grant_cleared", {28'h0, grant}, 32'h0);
    check("t5_timeout_window", {31'h0, (cyc - t0 >= 100) && (cyc - t0 <= 100 + BYTE_CYC + 20)}, 32'h1);
    rq[1].delete();
    hold[1] = 1'b0;
    wait_drain(2000, "t5_after");
    check("t5_timeout_count", tmo_cnt, 32'h1);
`else
    repeat (300) @(negedge sys_clk);
    check("t6_grant_held", {28'h0, grant}, 32'h2);
    check("t6_busy_held", {31'h0, busy}, 32'h1);
    check("t6_no_timeout", tmo_cnt, 32'h0);
    check("t6_cycles_waited", {31'h0, (cyc - t0 >= 300)}, 32'h1);
    exp_q.push_back('{dat: 8'hD1, gnt: 4'b0010});
    exp_q.push_back('{dat: 8'hD2, gnt: 4'b0010});
    exp_q.push_back('{dat: 8'hE0, gnt: 4'b0100});
    hold[1] = 1'b0;
    wait_drain(2000, "t6_after");
    check("t6_no_timeout_end", tmo_cnt, 32'h0);
`endif
    check("final_grant", {28'h0, grant}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout reached at %0t", $time);
    $fatal(1, "simulation time limit");
  end

endmodule
